// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit with architectural HI/LO registers. Operands
// come straight from the register-file read ports (rs_data, rt_data). One
// operation takes a fixed 33 clock edges after the start edge: 32 single-bit
// iterations (CALC) followed by one sign-correction/write-back edge (FIX).
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   launch an operation (honoured only while idle)
//   op       in   00=MULT 01=MULTU 10=DIV 11=DIVU
//   rs_data  in   operand A (multiplicand / dividend)
//   rt_data  in   operand B (multiplier / divisor)
//   mthi     in   write wb_data to HI (idle only, dropped if start is high)
//   mtlo     in   write wb_data to LO (idle only, dropped if start is high)
//   wb_data  in   data for mthi/mtlo
//   hi       out  HI register (product upper half / remainder)
//   lo       out  LO register (product lower half / quotient)
//   busy     out  registered, high while an operation is in flight
//   done     out  registered one-cycle pulse when an operation updates hi/lo
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // Counter value at which the final iteration is performed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_s;

  // Latched operation context; signedness is folded into the sign flags.
  logic                 op_div_r;
  logic                 sign_a_r;
  logic                 sign_b_r;
  logic [WIDTH-1:0]     a_r;        // |rs| (or raw rs for unsigned ops)
  logic [WIDTH-1:0]     b_r;        // |rt| (or raw rt for unsigned ops)
  logic [2*WIDTH-1:0]   acc_r;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [CNT_W-1:0]     cnt_r;

  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 busy_r;
  logic                 done_r;

  // Start-edge operand conditioning.
  logic                 start_signed_s;
  logic                 start_sign_a_s;
  logic                 start_sign_b_s;
  logic [WIDTH-1:0]     start_mag_a_s;
  logic [WIDTH-1:0]     start_mag_b_s;

  // Single iteration datapath.
  logic [WIDTH:0]       mul_addend_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic                 div_ge_s;
  logic [2*WIDTH-1:0]   acc_step_s;

  // Final sign-corrected results.
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     fix_hi_s;
  logic [WIDTH-1:0]     fix_lo_s;

  // Two's complement negation of an operand-width value.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation of a double-width value.
  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  // Next-state logic for the IDLE -> CALC -> FIX -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand magnitudes and sign flags captured on the start edge.
  always_comb begin
    start_signed_s = ~op[0];
    start_sign_a_s = start_signed_s & rs_data[WIDTH-1];
    start_sign_b_s = start_signed_s & rt_data[WIDTH-1];
    if (start_sign_a_s) begin
      start_mag_a_s = negate(rs_data);
    end else begin
      start_mag_a_s = rs_data;
    end
    if (start_sign_b_s) begin
      start_mag_b_s = negate(rt_data);
    end else begin
      start_mag_b_s = rt_data;
    end
  end

  // One iteration: shift-add multiply or restoring divide on magnitudes.
  always_comb begin
    if (acc_r[0]) begin
      mul_addend_s = {1'b0, a_r};
    end else begin
      mul_addend_s = {(WIDTH+1){1'b0}};
    end
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + mul_addend_s;
    // Remainder shifted left with the next dividend bit brought in.
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    if (op_div_r) begin
      if (div_ge_s) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry-out of the add lands in the top bit as the pair shifts right.
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the FIX edge.
  always_comb begin
    if (sign_a_r ^ sign_b_r) begin
      prod_s = negate_wide(acc_r);
    end else begin
      prod_s = acc_r;
    end
    quot_s = acc_r[WIDTH-1:0];
    rem_s  = acc_r[2*WIDTH-1:WIDTH];
    if (op_div_r) begin
      if (b_r == {WIDTH{1'b0}}) begin
        // Divide by zero: return the dividend exactly as it was presented.
        if (sign_a_r) begin
          fix_hi_s = negate(a_r);
        end else begin
          fix_hi_s = a_r;
        end
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        if (sign_a_r ^ sign_b_r) begin
          fix_lo_s = negate(quot_s);
        end else begin
          fix_lo_s = quot_s;
        end
        // Remainder takes the sign of the dividend (truncating division).
        if (sign_a_r) begin
          fix_hi_s = negate(rem_s);
        end else begin
          fix_hi_s = rem_s;
        end
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Operation context, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_div_r <= op[1];
            sign_a_r <= start_sign_a_s;
            sign_b_r <= start_sign_b_s;
            a_r      <= start_mag_a_s;
            b_r      <= start_mag_b_s;
            // Upper half cleared; lower half seeded with multiplier or dividend.
            if (op[1]) begin
              acc_r <= {{WIDTH{1'b0}}, start_mag_a_s};
            end else begin
              acc_r <= {{WIDTH{1'b0}}, start_mag_b_s};
            end
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // HI/LO registers: written by a finished operation or by mthi/mtlo when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else begin
      if (state_r == ST_FIX) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end else if ((state_r == ST_IDLE) && !start) begin
        if (mthi) begin
          hi_r <= wb_data;
        end
        if (mtlo) begin
          lo_r <= wb_data;
        end
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_r == ST_FIX);
    end
  end

endmodule
